pcpi_insn_loader: RTL and testbench

PCPI_INSN_LOADER -- requirements
Module: pcpi_insn_loader

---
 rtl/pcpi_insn_loader.sv | 158 +++++++++++++++
 tb/tb_pcpi_insn_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_insn_loader.sv
// Nibble-serial host loader that assembles a 32-bit instruction, issues it over PCPI and returns the result nibble by nibble.
// Optional ISSUE watchdog with sticky err flag is built when PCPI_TIMEOUT_EN is defined.
module pcpi_insn_loader #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strobe_in,
  input  logic [3:0]  nibble_in,
  output logic        ack_toggle,
  output logic [3:0]  nibble_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_ready,
  input  logic        pcpi_wait,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  logic [1:0]  state;
  logic [2:0]  count;
  logic [31:0] result;
  logic        strobe_s1, strobe_s2, strobe_s3;
  logic [3:0]  nibble_s1, nibble_s2;
  logic [1:0]  warm;
  logic        armed;
  logic        capture;
  logic        timeout;

  // Two-flop synchronizer plus a delay stage for edge detection. A strobe
  // already high at reset release must fall before it can be captured, so
  // capture is armed only after the pipeline has refilled and seen it low.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_s1 <= 1'b0;
      strobe_s2 <= 1'b0;
      strobe_s3 <= 1'b0;
      nibble_s1 <= 4'h0;
      nibble_s2 <= 4'h0;
      warm      <= 2'd0;
      armed     <= 1'b0;
    end else begin
      strobe_s1 <= strobe_in;
      strobe_s2 <= strobe_s1;
      strobe_s3 <= strobe_s2;
      nibble_s1 <= nibble_in;
      nibble_s2 <= nibble_s1;
      if (warm != 2'd2) warm <= warm + 2'd1;
      if (warm == 2'd2 && !strobe_s2) armed <= 1'b1;
    end
  end

  assign capture = armed & strobe_s2 & ~strobe_s3;

`ifdef PCPI_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_count;
  logic            err_q;

  assign timeout = (state == ST_ISSUE) && !pcpi_ready && !pcpi_wait &&
                   (wd_count == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_count <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != ST_ISSUE || pcpi_ready || pcpi_wait) wd_count <= '0;
      else                                               wd_count <= wd_count + 1'b1;
      if (timeout && !pcpi_ready)                err_q <= 1'b1;
      else if (state == ST_LOAD && capture)      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_wait;

  assign unused_wait = pcpi_wait;
  assign timeout     = 1'b0;
  assign err         = 1'b0;
`endif

  // NOTE: the instruction and result registers are reset like control state so a mid-transfer reset leaves no stale word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      count      <= 3'd0;
      pcpi_valid <= 1'b0;
      pcpi_insn  <= 32'h0;
      result     <= 32'h0;
      ack_toggle <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (capture) begin
            pcpi_insn[{count, 2'b00} +: 4] <= nibble_s2;
            count      <= count + 3'd1;
            ack_toggle <= ~ack_toggle;
            if (count == 3'd7) begin
              state      <= ST_ISSUE;
              pcpi_valid <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          // Ready wins over a simultaneous watchdog expiry.
          if (pcpi_ready) begin
            pcpi_valid <= 1'b0;
            if (pcpi_wr) begin
              result <= pcpi_rd;
              state  <= ST_READ;
            end else begin
              state <= ST_LOAD;
              done  <= 1'b1;
            end
          end else if (timeout) begin
            pcpi_valid <= 1'b0;
            state      <= ST_LOAD;
            done       <= 1'b1;
          end
        end
        ST_READ: begin
          if (capture) begin
            count      <= count + 3'd1;
            ack_toggle <= ~ack_toggle;
            if (count == 3'd7) begin
              state <= ST_LOAD;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    nibble_out = 4'h0;
    if (state == ST_READ) nibble_out = result[{count, 2'b00} +: 4];
  end

  assign busy = (state != ST_LOAD);

endmodule

// File: tb/tb_pcpi_insn_loader.sv
// Self-checking bench for pcpi_insn_loader: directed scenarios plus randomized transactions against a word-level model.
// Timeout scenario runs only when PCPI_TIMEOUT_EN is defined.
module tb_pcpi_insn_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe_in = 1'b0;
  logic [3:0]  nibble_in = 4'h0;
  logic        ack_toggle;
  logic [3:0]  nibble_out;
  logic        busy, done, err;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready = 1'b0;
  logic        pcpi_wait = 1'b0;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = 32'h0;

  int n_compared = 0;
  int n_mismatched = 0;
  int ack_events = 0;
  int done_cnt = 0;
  int exp_acks;
  int exp_done;

  pcpi_insn_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .strobe_in(strobe_in), .nibble_in(nibble_in),
    .ack_toggle(ack_toggle), .nibble_out(nibble_out), .busy(busy), .done(done),
    .err(err), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_ready(pcpi_ready), .pcpi_wait(pcpi_wait), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd)
  );

  always #5 clk = ~clk;

  always @(ack_toggle) ack_events++;
  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One host transfer: strobe high for three clocks (capture happens on the
  // third edge), then low for three. Returns at a falling edge.
  task automatic send_nibble(input logic [3:0] n);
    @(negedge clk);
    nibble_in = n;
    strobe_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    strobe_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) send_nibble(w[4*i +: 4]);
    exp_acks += 8;
  endtask

  task automatic pulse_ready(input logic wr, input logic [31:0] rd);
    @(negedge clk);
    pcpi_ready = 1'b1;
    pcpi_wr    = wr;
    pcpi_rd    = rd;
    @(negedge clk);
    pcpi_ready = 1'b0;
    pcpi_wr    = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [31:0] rd);
    for (int k = 0; k < 8; k++) begin
      check(tag, {28'h0, nibble_out}, (rd >> (4 * k)) & 32'hF);
      send_nibble(4'($urandom));
    end
    exp_acks += 8;
    exp_done += 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_insn", pcpi_insn, 32'h0);
    check("async_reset_ack", {31'h0, ack_toggle}, 32'h0);
    check("async_reset_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_acks = ack_events;
    exp_done = done_cnt;
  endtask

  initial begin : stimulus
    logic [31:0] word, rd, insn_hold;
    logic [3:0]  nib [8];
    logic        wr;
    int          acks_hold;

    exp_acks = 0;
    exp_done = 0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_valid", {31'h0, pcpi_valid}, 32'h0);
    check("reset_insn", pcpi_insn, 32'h0);
    check("reset_nibble_out", {28'h0, nibble_out}, 32'h0);
    check("reset_ack", {31'h0, ack_toggle}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_acks = ack_events;

    // Load 7,6,5,4,3,2,1,0 LSB nibble first.
    for (int i = 0; i < 8; i++) begin
      send_nibble(4'(7 - i));
      if (i == 3) check("load_partial_valid", {31'h0, pcpi_valid}, 32'h0);
    end
    exp_acks += 8;
    check("load_insn", pcpi_insn, 32'h01234567);
    check("load_valid", {31'h0, pcpi_valid}, 32'h1);
    check("load_busy", {31'h0, busy}, 32'h1);
    check("load_ack_events", 32'(ack_events), 32'(exp_acks));
    check("load_ack_level", {31'h0, ack_toggle}, 32'h0);
    check("issue_nibble_out", {28'h0, nibble_out}, 32'h0);

    // Strobes during ISSUE are ignored.
    send_nibble(4'hA);
    send_nibble(4'h5);
    check("issue_strobe_insn", pcpi_insn, 32'h01234567);
    check("issue_strobe_ack", 32'(ack_events), 32'(exp_acks));
    check("issue_strobe_valid", {31'h0, pcpi_valid}, 32'h1);

    // Result readback of 0xDEADBEEF.
    pulse_ready(1'b1, 32'hDEADBEEF);
    check("ready_valid_drop", {31'h0, pcpi_valid}, 32'h0);
    check("ready_busy", {31'h0, busy}, 32'h1);
    read_word("read_deadbeef", 32'hDEADBEEF);
    check("read_done_count", 32'(done_cnt), 32'(exp_done));
    check("read_busy_after", {31'h0, busy}, 32'h0);
    check("read_ack_events", 32'(ack_events), 32'(exp_acks));
    check("read_nibble_out_load", {28'h0, nibble_out}, 32'h0);

    // Write-less completion: straight back to LOAD with one done pulse.
    send_word(32'h89ABCDEF);
    check("nowr_insn", pcpi_insn, 32'h89ABCDEF);
    pulse_ready(1'b0, 32'h12345678);
    exp_done += 1;
    repeat (2) @(negedge clk);
    check("nowr_busy", {31'h0, busy}, 32'h0);
    check("nowr_valid", {31'h0, pcpi_valid}, 32'h0);
    check("nowr_done_count", 32'(done_cnt), 32'(exp_done));
    check("nowr_nibble_out", {28'h0, nibble_out}, 32'h0);

`ifdef PCPI_TIMEOUT_EN
    // Watchdog expiry after 16 idle ISSUE cycles; send_word returns 3 edges past entry.
    send_word(32'h0BADF00D);
    repeat (12) @(negedge clk);
    check("wd_valid_before", {31'h0, pcpi_valid}, 32'h1);
    check("wd_err_before", {31'h0, err}, 32'h0);
    @(negedge clk);
    check("wd_valid_after", {31'h0, pcpi_valid}, 32'h0);
    check("wd_err_after", {31'h0, err}, 32'h1);
    check("wd_busy_after", {31'h0, busy}, 32'h0);
    exp_done += 1;
    @(negedge clk);
    check("wd_done_count", 32'(done_cnt), 32'(exp_done));
    send_nibble(4'h3);
    check("wd_err_cleared", {31'h0, err}, 32'h0);
    for (int i = 1; i < 8; i++) send_nibble(4'h3);
    exp_acks += 8;
    pcpi_wait = 1'b1;
    repeat (100) @(negedge clk);
    check("wait_err", {31'h0, err}, 32'h0);
    check("wait_valid", {31'h0, pcpi_valid}, 32'h1);
    pulse_ready(1'b0, 32'h0);
    pcpi_wait = 1'b0;
    exp_done += 1;
    repeat (2) @(negedge clk);
    check("wait_done_count", 32'(done_cnt), 32'(exp_done));
    check("wait_err_final", {31'h0, err}, 32'h0);
`else
    // Without the watchdog ISSUE waits indefinitely.
    send_word(32'h0BADF00D);
    repeat (40) @(negedge clk);
    check("nowd_valid", {31'h0, pcpi_valid}, 32'h1);
    check("nowd_err", {31'h0, err}, 32'h0);
    pulse_ready(1'b0, 32'h0);
    exp_done += 1;
    repeat (2) @(negedge clk);
    check("nowd_done_count", 32'(done_cnt), 32'(exp_done));
`endif

    // Randomized transactions against the word-level model.
    for (int t = 0; t < 6; t++) begin
      word = 32'h0;
      for (int i = 0; i < 8; i++) begin
        nib[i] = 4'($urandom);
        word = word | (32'(nib[i]) << (4 * i));
      end
      for (int i = 0; i < 8; i++) send_nibble(nib[i]);
      exp_acks += 8;
      check("rand_insn", pcpi_insn, word);
      check("rand_valid", {31'h0, pcpi_valid}, 32'h1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      wr = 1'($urandom_range(0, 1));
      rd = $urandom;
      pulse_ready(wr, rd);
      check("rand_valid_drop", {31'h0, pcpi_valid}, 32'h0);
      if (wr) begin
        read_word("rand_read", rd);
      end else begin
        exp_done += 1;
        repeat (2) @(negedge clk);
      end
      check("rand_done_count", 32'(done_cnt), 32'(exp_done));
      check("rand_busy", {31'h0, busy}, 32'h0);
      check("rand_ack_events", 32'(ack_events), 32'(exp_acks));
    end

    // Reset mid-load with strobe held high across release.
    for (int i = 0; i < 5; i++) send_nibble(4'hF);
    @(negedge clk);
    strobe_in = 1'b1;
    nibble_in = 4'h9;
    apply_reset();
    acks_hold = ack_events;
    repeat (10) @(negedge clk);
    check("held_strobe_ack", 32'(ack_events), 32'(acks_hold));
    check("held_strobe_insn", pcpi_insn, 32'h0);
    strobe_in = 1'b0;
    repeat (5) @(negedge clk);
    word = $urandom;
    send_word(word);
    exp_acks = acks_hold + 8;
    check("post_reset_insn", pcpi_insn, word);
    check("post_reset_valid", {31'h0, pcpi_valid}, 32'h1);
    check("post_reset_ack_events", 32'(ack_events), 32'(exp_acks));
    insn_hold = pcpi_insn;
    pulse_ready(1'b1, ~word);
    read_word("post_reset_read", ~word);
    check("post_reset_done", 32'(done_cnt), 32'(exp_done));
    check("post_reset_insn_hold", pcpi_insn, insn_hold);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
